// File: rtl/tr_pulse_gen.sv
// Step/direction pulse generator with AUTO, MOVE and MOVE_N run modes, a
// graceful stop, direction setup delay before the first step, and a period
// shadow that only takes effect at period boundaries.
module tr_pulse_gen #(
  parameter int SIZE       = 16,
  parameter int CNT_W      = 16,
  parameter int N_HAND     = 100,
  parameter int DIR_SETUP  = 4,
  parameter int DEF_PERIOD = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_v,
  input  logic [SIZE-1:0]  period,
  input  logic [1:0]       mode,
  input  logic             start,
  input  logic             stop,
  input  logic             dir_in,
  input  logic [CNT_W-1:0] n_pulses,
  output logic             drv_step,
  output logic             drv_step_n,
  output logic             drv_dir,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulse_cnt
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] DIR_WAIT = 2'd1;
  localparam logic [1:0] RUN      = 2'd2;
  localparam logic [1:0] FINISH   = 2'd3;

  localparam logic [1:0] MODE_AUTO   = 2'b00;
  localparam logic [1:0] MODE_MOVE   = 2'b01;
  localparam logic [1:0] MODE_RSVD   = 2'b11;

  localparam int WAIT_W = (DIR_SETUP > 1) ? $clog2(DIR_SETUP) : 1;

  logic [1:0]       state_reg, state_next;
  logic [SIZE-1:0]  shadow_reg;
  logic [SIZE-1:0]  act_reg, act_next;
  logic [SIZE-1:0]  phase_reg, phase_next;
  logic [1:0]       mode_reg, mode_next;
  logic [CNT_W-1:0] target_reg, target_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             dir_reg, dir_next;
  logic             stop_reg, stop_next;
  logic [WAIT_W-1:0] wait_reg, wait_next;
  logic             step_reg, step_next;
  logic             step_n_reg;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;

  logic [SIZE-1:0]  p_eff;
  logic [SIZE-1:0]  phase_inc;
  logic [CNT_W-1:0] cnt_inc;
  logic             period_end;
  logic             target_hit;
  logic             stop_seen;
  logic             begin_period;

  // Effective period is clamped so the pulse always has >=1 high and >=3 low cycles.
  assign p_eff      = (shadow_reg < SIZE'(4)) ? SIZE'(4) : shadow_reg;
  assign phase_inc  = phase_reg + SIZE'(1);
  assign cnt_inc    = (cnt_reg == {CNT_W{1'b1}}) ? cnt_reg : cnt_reg + CNT_W'(1);
  assign period_end = (phase_reg == act_reg - SIZE'(1));
  assign target_hit = (mode_reg != MODE_AUTO) && (cnt_reg >= target_reg);
  assign stop_seen  = stop_reg | stop;

  // Period shadow: loaded in any state, consumed only at period starts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) shadow_reg <= SIZE'(DEF_PERIOD);
    else if (d_v) shadow_reg <= period;
  end

  // Next-state and next-output logic for the run sequencer.
  always_comb begin
    state_next   = state_reg;
    act_next     = act_reg;
    phase_next   = phase_reg;
    mode_next    = mode_reg;
    target_next  = target_reg;
    cnt_next     = cnt_reg;
    dir_next     = dir_reg;
    stop_next    = stop_reg;
    wait_next    = wait_reg;
    step_next    = 1'b0;
    done_next    = 1'b0;
    begin_period = 1'b0;

    case (state_reg)
      IDLE: begin
        stop_next = 1'b0;
        if (start && mode != MODE_RSVD) begin
          mode_next   = mode;
          target_next = (mode == MODE_MOVE) ? CNT_W'(N_HAND) : n_pulses;
          cnt_next    = '0;
          if (dir_in != dir_reg) begin
            dir_next   = dir_in;
            wait_next  = WAIT_W'(DIR_SETUP - 1);
            state_next = DIR_WAIT;
          end else if (mode != MODE_AUTO && mode != MODE_MOVE && n_pulses == '0) begin
            state_next = FINISH;
            done_next  = 1'b1;
          end else begin
            begin_period = 1'b1;
          end
        end
      end
      DIR_WAIT: begin
        stop_next = stop_seen;
        if (wait_reg == '0) begin
          // cnt_reg is zero here, so target_hit means a zero-pulse MOVE_N.
          if (stop_seen || target_hit) begin
            state_next = FINISH;
            done_next  = 1'b1;
          end else begin
            begin_period = 1'b1;
          end
        end else begin
          wait_next = wait_reg - WAIT_W'(1);
        end
      end
      RUN: begin
        stop_next = stop_seen;
        if (period_end) begin
          if (stop_seen || target_hit) begin
            state_next = FINISH;
            done_next  = 1'b1;
          end else begin
            begin_period = 1'b1;
          end
        end else begin
          phase_next = phase_inc;
          step_next  = (phase_inc < (act_reg >> 2));
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // A period start captures the shadow and counts a new pulse.
    if (begin_period) begin
      state_next = RUN;
      phase_next = '0;
      act_next   = p_eff;
      step_next  = 1'b1;
      cnt_next   = (state_reg == RUN) ? cnt_inc : CNT_W'(1);
    end
  end

  assign busy_next = (state_next != IDLE);

  // State and output registers; reset forces IDLE with quiet outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      act_reg    <= SIZE'(4);
      phase_reg  <= '0;
      mode_reg   <= MODE_AUTO;
      target_reg <= '0;
      cnt_reg    <= '0;
      dir_reg    <= 1'b0;
      stop_reg   <= 1'b0;
      wait_reg   <= '0;
      step_reg   <= 1'b0;
      step_n_reg <= 1'b1;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      act_reg    <= act_next;
      phase_reg  <= phase_next;
      mode_reg   <= mode_next;
      target_reg <= target_next;
      cnt_reg    <= cnt_next;
      dir_reg    <= dir_next;
      stop_reg   <= stop_next;
      wait_reg   <= wait_next;
      step_reg   <= step_next;
      step_n_reg <= ~step_reg;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
    end
  end

  assign drv_step   = step_reg;
  assign drv_step_n = step_n_reg;
  assign drv_dir    = dir_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign pulse_cnt  = cnt_reg;

endmodule

// File: tb/tb_tr_pulse_gen.sv
// Scoreboard bench for tr_pulse_gen: expected pulses and run results are
// queued at stimulus time and compared by a negedge monitor.
module tb_tr_pulse_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        d_v = 1'b0;
  logic [15:0] period = '0;
  logic [1:0]  mode = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        dir_in = 1'b0;
  logic [15:0] n_pulses = '0;
  logic        drv_step, drv_step_n, drv_dir, busy, done;
  logic [15:0] pulse_cnt;

  typedef struct {
    int high;
    int per;
  } pulse_t;

  pulse_t pq[$];
  int     rq[$];

  int n_checks = 0;
  int n_pass   = 0;

  int  cyc = 0;
  int  rise_cyc = 0;
  int  high_cyc = 0;
  bit  have_pulse = 0;
  logic prev_step = 1'b0;
  bit  prev_rst = 0;

  logic s1_dir, s1_busy, s1_done;
  int   lat;

  tr_pulse_gen dut (
    .clk(clk), .rst(rst), .d_v(d_v), .period(period), .mode(mode),
    .start(start), .stop(stop), .dir_in(dir_in), .n_pulses(n_pulses),
    .drv_step(drv_step), .drv_step_n(drv_step_n), .drv_dir(drv_dir),
    .busy(busy), .done(done), .pulse_cnt(pulse_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  task automatic finalize(input int per);
    pulse_t e;
    chk("pulse_expected", 32'(pq.size() != 0), 1);
    if (pq.size() != 0) begin
      e = pq.pop_front();
      $display("pulse @%0d: high=%0d period=%0d (expect %0d/%0d)", cyc, high_cyc, per, e.high, e.per);
      chk("pulse_high", high_cyc, e.high);
      chk("pulse_period", per, e.per);
    end
  endtask

  // Monitor: measures each step pulse and each run end on the falling clock edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        pq.delete();
        rq.delete();
        have_pulse = 0;
        prev_step  = 1'b0;
        prev_rst   = 0;
      end else begin
        if (prev_rst) chk("step_n", drv_step_n, !prev_step);
        if (drv_step && !prev_step) begin
          if (have_pulse) finalize(cyc - rise_cyc);
          rise_cyc   = cyc;
          have_pulse = 1;
        end
        if (!drv_step && prev_step) high_cyc = cyc - rise_cyc;
        if (done) begin
          if (have_pulse) finalize(cyc - rise_cyc);
          have_pulse = 0;
          chk("run_expected", 32'(rq.size() != 0), 1);
          if (rq.size() != 0) begin
            int e;
            e = rq.pop_front();
            $display("run end @%0d: pulse_cnt=%0d (expect %0d)", cyc, pulse_cnt, e);
            chk("run_pulse_cnt", pulse_cnt, e);
          end
        end
        prev_step = drv_step;
        prev_rst  = 1;
      end
    end
  end

  task automatic load_period(input logic [15:0] p);
    @(negedge clk);
    d_v = 1'b1; period = p;
    @(negedge clk);
    d_v = 1'b0;
  endtask

  task automatic do_start(input logic [1:0] m, input logic d, input logic [15:0] n,
                          input bit want_step, output int l);
    @(negedge clk);
    start = 1'b1; mode = m; dir_in = d; n_pulses = n;
    @(negedge clk);
    start = 1'b0;
    s1_dir = drv_dir; s1_busy = busy; s1_done = done;
    l = 1;
    if (want_step) begin
      while (drv_step !== 1'b1 && l < 100) begin
        @(negedge clk);
        l++;
      end
    end
  endtask

  task automatic run_wait(input int budget);
    int k;
    k = 0;
    while (done !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("run_end_seen", done, 1);
    @(negedge clk);
    chk("busy_after_done", busy, 0);
    chk("done_width", done, 0);
  endtask

  task automatic push_pulses(input int cnt, input int h, input int p);
    pulse_t e;
    e.high = h;
    e.per  = p;
    for (int i = 0; i < cnt; i++) pq.push_back(e);
  endtask

  initial begin
    // Power-up reset values.
    repeat (3) @(negedge clk);
    chk("rst_step", drv_step, 0);
    chk("rst_step_n", drv_step_n, 1);
    chk("rst_dir", drv_dir, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", pulse_cnt, 0);
    #1 rst = 1'b1;

    // Reset mid-pulse of an AUTO run after a direction change and a period load.
    load_period(16'd30);
    do_start(2'b00, 1'b1, 16'd0, 1, lat);
    chk("lat_dir_change_a", lat, 5);
    chk("mid_run_step", drv_step, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_step", drv_step, 0);
    chk("arst_step_n", drv_step_n, 1);
    chk("arst_dir", drv_dir, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_cnt", pulse_cnt, 0);
    @(negedge clk);
    #1 rst = 1'b1;

    // Default period after reset: 1000 with 250 high.
    push_pulses(1, 250, 1000);
    rq.push_back(1);
    do_start(2'b10, 1'b0, 16'd1, 1, lat);
    chk("lat_default", lat, 1);
    chk("busy_first", s1_busy, 1);
    run_wait(1100);

    // MOVE_N, period 20, five pulses.
    load_period(16'd20);
    push_pulses(5, 5, 20);
    rq.push_back(5);
    do_start(2'b10, 1'b0, 16'd5, 1, lat);
    chk("lat_move_n", lat, 1);
    run_wait(200);

    // MOVE (hand) mode with period clamped from 2 to 4.
    load_period(16'd2);
    push_pulses(100, 1, 4);
    rq.push_back(100);
    do_start(2'b01, 1'b0, 16'd7, 1, lat);
    run_wait(500);

    // AUTO with a period update and a stop, both mid-pulse.
    load_period(16'd40);
    push_pulses(1, 10, 40);
    push_pulses(1, 4, 16);
    rq.push_back(2);
    do_start(2'b00, 1'b0, 16'd0, 1, lat);
    d_v = 1'b1; period = 16'd16;
    @(negedge clk);
    d_v = 1'b0;
    begin
      int k;
      k = 0;
      while (drv_step !== 1'b0 && k < 100) begin @(negedge clk); k++; end
      while (drv_step !== 1'b1 && k < 100) begin @(negedge clk); k++; end
      chk("auto_second_rise", drv_step, 1);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    run_wait(100);

    // Direction change delays the first step; same direction does not.
    push_pulses(1, 4, 16);
    rq.push_back(1);
    do_start(2'b10, 1'b1, 16'd1, 1, lat);
    chk("dir_at_k1", s1_dir, 1);
    chk("lat_dir_change", lat, 5);
    run_wait(100);
    push_pulses(1, 4, 16);
    rq.push_back(1);
    do_start(2'b10, 1'b1, 16'd1, 1, lat);
    chk("lat_same_dir", lat, 1);
    run_wait(100);

    // Stop during the direction wait: no pulse, direction still updated.
    rq.push_back(0);
    do_start(2'b10, 1'b0, 16'd3, 0, lat);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    run_wait(20);
    chk("dir_after_stop", drv_dir, 0);

    // MOVE_N with zero pulses goes straight to FINISH.
    rq.push_back(0);
    do_start(2'b10, 1'b0, 16'd0, 0, lat);
    chk("zero_done", s1_done, 1);
    chk("zero_busy", s1_busy, 1);
    @(negedge clk);
    chk("zero_busy_after", busy, 0);
    chk("zero_done_after", done, 0);

    // Reserved mode is ignored.
    do_start(2'b11, 1'b1, 16'd5, 0, lat);
    chk("rsvd_busy", s1_busy, 0);
    chk("rsvd_dir", s1_dir, 0);
    repeat (3) @(negedge clk);
    chk("rsvd_busy_later", busy, 0);

    // A start while busy does not disturb the run in progress.
    push_pulses(3, 4, 16);
    rq.push_back(3);
    do_start(2'b10, 1'b0, 16'd3, 1, lat);
    start = 1'b1; mode = 2'b00; dir_in = 1'b1; n_pulses = 16'd50;
    @(negedge clk);
    start = 1'b0;
    run_wait(200);
    chk("busy_start_dir", drv_dir, 0);

    repeat (3) @(negedge clk);
    chk("pulse_q_left", pq.size(), 0);
    chk("run_q_left", rq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
